// File: rtl/nh_lcd_data_reader.sv
// Read side of the NH LCD 8080-style bus: sends one command, drops the dummy byte and
// packs each following R,G,B byte triple into a 24-bit word written to a ping-pong FIFO.
module nh_lcd_data_reader #(
    parameter int unsigned READ_PULSE  = 2,
    parameter logic [7:0]  CMD_DEFAULT = 8'h2E
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  cmd_i,
    input  logic [31:0] num_pixels_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [1:0]  fifo_rdy_i,
    output logic [1:0]  fifo_act_o,
    input  logic [23:0] fifo_size_i,
    output logic        fifo_stb_o,
    output logic [23:0] fifo_data_o,
    output logic        cmd_mode_o,
    output logic [7:0]  data_out_o,
    input  logic [7:0]  data_in_i,
    output logic        write_o,
    output logic        read_o,
    output logic        data_out_en_o,
    output logic [31:0] debug_o
);

    localparam int unsigned   TW         = (READ_PULSE > 1) ? $clog2(READ_PULSE) : 1;
    localparam logic [TW-1:0] PULSE_LAST = TW'(READ_PULSE - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WRITE_CMD  = 4'd1,
        TURNAROUND = 4'd2,
        READ_HI    = 4'd3,
        READ_LO    = 4'd4,
        GET_FIFO   = 4'd5,
        PUSH       = 4'd6,
        RELEASE    = 4'd7,
        FINISH     = 4'd8
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    byteIdx_q, byteIdx_d;
    logic          pixelReady_q, pixelReady_d;
    logic [7:0]    rByte_q, rByte_d;
    logic [7:0]    gByte_q, gByte_d;
    logic [7:0]    bByte_q, bByte_d;
    logic [31:0]   total_q, total_d;
    logic [31:0]   pixelCount_q, pixelCount_d;
    logic [23:0]   chanCount_q, chanCount_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    fifoAct_q, fifoAct_d;
    logic          fifoStb_q, fifoStb_d;
    logic [23:0]   fifoData_q, fifoData_d;
    logic          cmdMode_q, cmdMode_d;
    logic [7:0]    dataOut_q, dataOut_d;
    logic          write_q, write_d;
    logic          read_q, read_d;
    logic          dataOutEn_q, dataOutEn_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            byteIdx_q    <= 2'd0;
            pixelReady_q <= 1'b0;
            rByte_q      <= 8'd0;
            gByte_q      <= 8'd0;
            bByte_q      <= 8'd0;
            total_q      <= 32'd0;
            pixelCount_q <= 32'd0;
            chanCount_q  <= 24'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fifoAct_q    <= 2'b00;
            fifoStb_q    <= 1'b0;
            fifoData_q   <= 24'd0;
            cmdMode_q    <= 1'b1;
            dataOut_q    <= CMD_DEFAULT;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            dataOutEn_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            byteIdx_q    <= byteIdx_d;
            pixelReady_q <= pixelReady_d;
            rByte_q      <= rByte_d;
            gByte_q      <= gByte_d;
            bByte_q      <= bByte_d;
            total_q      <= total_d;
            pixelCount_q <= pixelCount_d;
            chanCount_q  <= chanCount_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fifoAct_q    <= fifoAct_d;
            fifoStb_q    <= fifoStb_d;
            fifoData_q   <= fifoData_d;
            cmdMode_q    <= cmdMode_d;
            dataOut_q    <= dataOut_d;
            write_q      <= write_d;
            read_q       <= read_d;
            dataOutEn_q  <= dataOutEn_d;
        end
    end

    // Every bus/FIFO output is registered and set on the transition into the state that owns it.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        byteIdx_d    = byteIdx_q;
        pixelReady_d = pixelReady_q;
        rByte_d      = rByte_q;
        gByte_d      = gByte_q;
        bByte_d      = bByte_q;
        total_d      = total_q;
        pixelCount_d = pixelCount_q;
        chanCount_d  = chanCount_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fifoAct_d    = fifoAct_q;
        fifoStb_d    = 1'b0;
        fifoData_d   = fifoData_q;
        cmdMode_d    = cmdMode_q;
        dataOut_d    = dataOut_q;
        write_d      = 1'b0;
        read_d       = read_q;
        dataOutEn_d  = dataOutEn_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_pixels_i != 32'd0) begin
                        total_d      = num_pixels_i;
                        pixelCount_d = 32'd0;
                        chanCount_d  = 24'd0;
                        byteIdx_d    = 2'd0;
                        pixelReady_d = 1'b0;
                        busy_d       = 1'b1;
                        cmdMode_d    = 1'b0;
                        dataOut_d    = cmd_i;
                        write_d      = 1'b1;
                        state_d      = WRITE_CMD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            WRITE_CMD: begin
                cmdMode_d   = 1'b1;
                dataOutEn_d = 1'b0;
                state_d     = TURNAROUND;
            end

            TURNAROUND: begin
                read_d  = 1'b1;
                timer_d = '0;
                state_d = READ_HI;
            end

            READ_HI: begin
                if (timer_q == PULSE_LAST) begin
                    case (byteIdx_q)
                        2'd1: rByte_d = data_in_i;
                        2'd2: gByte_d = data_in_i;
                        2'd3: begin
                            bByte_d      = data_in_i;
                            pixelReady_d = 1'b1;
                        end
                        default: ;
                    endcase
                    read_d  = 1'b0;
                    timer_d = '0;
                    state_d = READ_LO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // The dummy byte and each completed pixel go through GET_FIFO before the next R.
            READ_LO: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    if (byteIdx_q == 2'd0 || byteIdx_q == 2'd3) begin
                        byteIdx_d = 2'd1;
                        state_d   = GET_FIFO;
                    end else begin
                        byteIdx_d = byteIdx_q + 2'd1;
                        read_d    = 1'b1;
                        state_d   = READ_HI;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            GET_FIFO: begin
                if (pixelReady_q) begin
                    pixelReady_d = 1'b0;
                    fifoStb_d    = 1'b1;
                    fifoData_d   = {rByte_q, gByte_q, bByte_q};
                    pixelCount_d = pixelCount_q + 32'd1;
                    chanCount_d  = chanCount_q + 24'd1;
                    state_d      = PUSH;
                end else if (fifoAct_q != 2'b00) begin
                    read_d  = 1'b1;
                    timer_d = '0;
                    state_d = READ_HI;
                end else if (fifo_rdy_i[0]) begin
                    fifoAct_d   = 2'b01;
                    chanCount_d = 24'd0;
                    read_d      = 1'b1;
                    timer_d     = '0;
                    state_d     = READ_HI;
                end else if (fifo_rdy_i[1]) begin
                    fifoAct_d   = 2'b10;
                    chanCount_d = 24'd0;
                    read_d      = 1'b1;
                    timer_d     = '0;
                    state_d     = READ_HI;
                end
            end

            PUSH: begin
                if (chanCount_q == fifo_size_i || pixelCount_q == total_q) begin
                    fifoAct_d = 2'b00;
                    state_d   = RELEASE;
                end else begin
                    state_d = GET_FIFO;
                end
            end

            RELEASE: begin
                if (pixelCount_q != total_q) begin
                    state_d = GET_FIFO;
                end else begin
                    dataOutEn_d = 1'b1;
                    cmdMode_d   = 1'b1;
                    dataOut_d   = CMD_DEFAULT;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fifo_act_o    = fifoAct_q;
    assign fifo_stb_o    = fifoStb_q;
    assign fifo_data_o   = fifoData_q;
    assign cmd_mode_o    = cmdMode_q;
    assign data_out_o    = dataOut_q;
    assign write_o       = write_q;
    assign read_o        = read_q;
    assign data_out_en_o = dataOutEn_q;
    assign debug_o       = {24'd0, fifoAct_q, write_q, read_q, state_q};

endmodule

// File: tb/tb_nh_lcd_data_reader.sv
// Directed bench for nh_lcd_data_reader: a bus responder feeds read bytes and a
// scoreboard of expected {channel, RGB} words is checked on every FIFO strobe.
module tb_nh_lcd_data_reader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [7:0]  cmdIn;
    logic [31:0] numPixels;
    logic        busy;
    logic        done;
    logic [1:0]  fifoRdy;
    logic [1:0]  fifoAct;
    logic [23:0] fifoSize;
    logic        fifoStb;
    logic [23:0] fifoData;
    logic        cmdMode;
    logic [7:0]  dataOut;
    logic [7:0]  dataIn = 8'h00;
    logic        writeOut;
    logic        readOut;
    logic        dataOutEn;
    logic [31:0] debug;

    int testsRun    = 0;
    int testsFailed = 0;
    int stbCount    = 0;
    int readRises   = 0;
    logic prevRead  = 1'b0;

    logic [7:0]  busQ[$];
    logic [25:0] expQ[$];

    nh_lcd_data_reader #(
        .READ_PULSE (2),
        .CMD_DEFAULT(8'h2E)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .start_i      (start),
        .cmd_i        (cmdIn),
        .num_pixels_i (numPixels),
        .busy_o       (busy),
        .done_o       (done),
        .fifo_rdy_i   (fifoRdy),
        .fifo_act_o   (fifoAct),
        .fifo_size_i  (fifoSize),
        .fifo_stb_o   (fifoStb),
        .fifo_data_o  (fifoData),
        .cmd_mode_o   (cmdMode),
        .data_out_o   (dataOut),
        .data_in_i    (dataIn),
        .write_o      (writeOut),
        .read_o       (readOut),
        .data_out_en_o(dataOutEn),
        .debug_o      (debug)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] num);
        @(negedge clk);
        cmdIn     = cmd;
        numPixels = num;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic pushPixel(input logic [1:0] act, input logic [23:0] rgb);
        busQ.push_back(rgb[23:16]);
        busQ.push_back(rgb[15:8]);
        busQ.push_back(rgb[7:0]);
        expQ.push_back({act, rgb});
    endtask

    task automatic waitDone(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    // Panel model: a new byte appears on the bus whenever the read strobe rises.
    always @(negedge clk) begin
        if (readOut === 1'b1 && prevRead === 1'b0) begin
            readRises++;
            if (busQ.size() > 0) dataIn = busQ.pop_front();
            else                 dataIn = 8'h00;
        end
        prevRead = readOut;
    end

    // Scoreboard: every strobe must match the oldest expected {channel, RGB} word.
    always @(negedge clk) begin
        if (rstN === 1'b1 && fifoStb === 1'b1) begin
            stbCount++;
            if (expQ.size() == 0) begin
                checkOutput("extraStb", 32'(fifoStb), 32'd0);
            end else begin
                logic [25:0] want;
                want = expQ.pop_front();
                checkOutput("stbWord", {6'd0, fifoAct, fifoData}, {6'd0, want});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    stbBase;
        int    rdBase;
        bit    seen;
        bit    sawRead;
        logic [23:0] px;

        rstN      = 1'b0;
        start     = 1'b0;
        cmdIn     = 8'h00;
        numPixels = 32'd0;
        fifoRdy   = 2'b00;
        fifoSize  = 24'd16;
        repeat (3) @(negedge clk);

        checkOutput("rstBusy",    32'(busy),      32'd0);
        checkOutput("rstDone",    32'(done),      32'd0);
        checkOutput("rstCmdMode", 32'(cmdMode),   32'd1);
        checkOutput("rstDataOut", 32'(dataOut),   32'h2E);
        checkOutput("rstOutEn",   32'(dataOutEn), 32'd1);
        checkOutput("rstWrite",   32'(writeOut),  32'd0);
        checkOutput("rstRead",    32'(readOut),   32'd0);
        checkOutput("rstAct",     32'(fifoAct),   32'd0);
        checkOutput("rstStb",     32'(fifoStb),   32'd0);
        checkOutput("rstData",    32'(fifoData),  32'd0);
        checkOutput("rstDebug",   32'(debug[31:4]), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Single pixel on channel 0
        fifoRdy = 2'b01;
        busQ.push_back(8'h55);
        pushPixel(2'b01, 24'hAA1122);
        stbBase = stbCount;
        applyStimulus(8'h2E, 32'd1);
        checkOutput("t1Write",   32'(writeOut), 32'd1);
        checkOutput("t1CmdMode", 32'(cmdMode),  32'd0);
        checkOutput("t1Busy",    32'(busy),     32'd1);
        checkOutput("t1Debug",   32'(debug[31:4]), 32'h2);
        waitDone("t1Done");
        checkOutput("t1BusyLow", 32'(busy),      32'd0);
        checkOutput("t1ActOff",  32'(fifoAct),   32'd0);
        checkOutput("t1OutEn",   32'(dataOutEn), 32'd1);
        checkOutput("t1IdleCmd", 32'(dataOut),   32'h2E);
        checkOutput("t1Strobes", 32'(stbCount - stbBase), 32'd1);
        checkOutput("t1QEmpty",  32'(expQ.size()), 32'd0);
        @(negedge clk);
        checkOutput("t1DonePulse", 32'(done), 32'd0);

        // Four pixels over two channels of three words each
        fifoRdy  = 2'b11;
        fifoSize = 24'd3;
        busQ.push_back(8'hE7);
        for (int p = 0; p < 4; p++) begin
            px = 24'($urandom);
            pushPixel((p < 3) ? 2'b01 : 2'b10, px);
        end
        stbBase = stbCount;
        applyStimulus(8'h3E, 32'd4);
        checkOutput("t2CmdByte", 32'(dataOut), 32'h3E);
        checkOutput("t2CmdWrite", 32'(writeOut), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifoAct === 2'b01) begin seen = 1'b1; break; end
        end
        checkOutput("t2Ch0Active", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fifoAct === 2'b00) begin seen = 1'b1; break; end
        end
        checkOutput("t2Ch0Release", 32'(seen), 32'd1);
        checkOutput("t2Ch0Words", 32'(stbCount - stbBase), 32'd3);
        fifoRdy = 2'b10;
        waitDone("t2Done");
        checkOutput("t2Strobes", 32'(stbCount - stbBase), 32'd4);
        checkOutput("t2ActOff",  32'(fifoAct), 32'd0);
        checkOutput("t2QEmpty",  32'(expQ.size()), 32'd0);
        fifoSize = 24'd16;

        // No free channel after the dummy read: bus must stay quiet
        fifoRdy = 2'b00;
        busQ.push_back(8'h99);
        pushPixel(2'b01, 24'h5AC30F);
        stbBase = stbCount;
        applyStimulus(8'h2E, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readOut === 1'b1) begin seen = 1'b1; break; end
        end
        checkOutput("t3DummyRead", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (readOut === 1'b0) begin seen = 1'b1; break; end
        end
        checkOutput("t3DummyEnd", 32'(seen), 32'd1);
        sawRead = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (readOut !== 1'b0) sawRead = 1'b1;
        end
        checkOutput("t3QuietRead", 32'(sawRead), 32'd0);
        checkOutput("t3QuietStb",  32'(stbCount - stbBase), 32'd0);
        fifoRdy = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (readOut === 1'b1) seen = 1'b1;
        end
        checkOutput("t3Resume", 32'(seen), 32'd1);
        waitDone("t3Done");
        checkOutput("t3Strobes", 32'(stbCount - stbBase), 32'd1);

        // Reset while the G byte is being read
        busQ.push_back(8'h01);
        pushPixel(2'b01, 24'h123456);
        pushPixel(2'b01, 24'h789ABC);
        rdBase = readRises;
        applyStimulus(8'h2E, 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (readRises >= rdBase + 3) begin seen = 1'b1; break; end
        end
        checkOutput("t4ReachG", 32'(seen), 32'd1);
        checkOutput("t4MidRead", 32'(readOut), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("t4RstRead",    32'(readOut),   32'd0);
        checkOutput("t4RstBusy",    32'(busy),      32'd0);
        checkOutput("t4RstAct",     32'(fifoAct),   32'd0);
        checkOutput("t4RstOutEn",   32'(dataOutEn), 32'd1);
        checkOutput("t4RstCmdMode", 32'(cmdMode),   32'd1);
        checkOutput("t4RstDataOut", 32'(dataOut),   32'h2E);
        checkOutput("t4RstData",    32'(fifoData),  32'd0);
        checkOutput("t4RstStb",     32'(fifoStb),   32'd0);
        busQ.delete();
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        busQ.push_back(8'h77);
        pushPixel(2'b01, 24'hFEDCBA);
        stbBase = stbCount;
        applyStimulus(8'h2E, 32'd1);
        waitDone("t4AfterDone");
        checkOutput("t4AfterStb", 32'(stbCount - stbBase), 32'd1);

        // Zero-pixel request, then starts ignored while busy
        stbBase = stbCount;
        applyStimulus(8'h2E, 32'd0);
        checkOutput("t5ZeroDone",  32'(done),     32'd1);
        checkOutput("t5ZeroWrite", 32'(writeOut), 32'd0);
        checkOutput("t5ZeroBusy",  32'(busy),     32'd0);
        @(negedge clk);
        checkOutput("t5ZeroPulse", 32'(done), 32'd0);
        busQ.push_back(8'h42);
        pushPixel(2'b01, 24'h0A0B0C);
        pushPixel(2'b01, 24'hD0E0F0);
        applyStimulus(8'h2E, 32'd2);
        repeat (4) begin
            repeat (3) @(negedge clk);
            cmdIn     = 8'hC5;
            numPixels = 32'd5;
            start     = 1'b1;
            @(negedge clk);
            start     = 1'b0;
        end
        checkOutput("t5StillBusy", 32'(busy), 32'd1);
        waitDone("t5Done");
        checkOutput("t5Strobes", 32'(stbCount - stbBase), 32'd2);
        checkOutput("t5QEmpty",  32'(expQ.size()), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t5NoRestart", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
